matrix_key_emulator: RTL and testbench
======================================

# matrix_key_emulator

Synthesizable model of a 4x4 active-low membrane keypad, the contact side of the keypad matrix scanned by the calculator's key scanner. It takes one key-press command at a time (key code plus hold time), closes the corresponding row/column contact with optional contact bounce on press and release, and drives `row_data` in response to the scanner's `col_data` strobes. It is used in self-checking benches and on-board loopback, with `row_data` wired straight to the scanner's row input.

## Interface
Parameters:
- `BOUNCE_CYCLES`, default 16: length in clk cycles of each bounce window (press and release). Legal range is 1..255.

Ports:
- `clk`: input, 1 bit. Single clock.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `cmd_valid`: input, 1 bit. A press command is present.
- `cmd_ready`: output, 1 bit. The emulator is idle and can accept a command.
- `cmd_key`: input, 4 bits. Key code, 0x0..0xF.
- `cmd_hold`: input, 24 bits. Number of cycles the contact stays cleanly closed. A value of 0 is treated as 1.
- `col_data`: input, 4 bits. Column strobes from the scanner, active-low.
- `row_data`: output, 4 bits. Row sense lines, active-low, registered.
- `busy`: output, 1 bit. A command is in progress.
- `done`: output, 1 bit. One-cycle pulse when a command completes.

## Operation
- Key map as key = (row r, col c). Row r drives `row_data[3-r]`; col c is sensed on `col_data[3-c]`.
  - r0: keys 1, 2, 3, A
  - r1: keys 4, 5, 6, B
  - r2: keys 7, 8, 9, C
  - r3: keys F, 0, E, D
- Contact model: when `contact`=1, `row_data[3-r]` = `col_data[3-c]`; all other row bits are 1. When `contact`=0, `row_data` = 4'hF.
- Any number of low column bits is legal. For example, `col_data`=4'h0 with contact closed pulls row r low.
- States: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE.
  - IDLE: `cmd_ready`=1, `contact`=0. On `cmd_valid`&`cmd_ready`, latch `cmd_key` and `cmd_hold` and go to PRESS_BOUNCE.
  - PRESS_BOUNCE: `contact` = `lfsr[0]` each cycle. After `BOUNCE_CYCLES` cycles, go to HOLD.
  - HOLD: `contact`=1 for max(`cmd_hold`,1) cycles, then go to RELEASE_BOUNCE.
  - RELEASE_BOUNCE: `contact` = `lfsr[0]`. After `BOUNCE_CYCLES` cycles, go to IDLE, with `contact`=0 and `done`=1 for one cycle.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Reset seed is 8'hA5.
  - Advances only in the bounce states. The sequence is deterministic across commands.
- `busy` = !IDLE. `cmd_ready` = IDLE.
- Commands presented while busy are not accepted and remain pending. There is no queue.
- Reset mid-command: the contact opens immediately. All outputs take their reset values and the latched command is discarded.

## Timing
- Reset values: `row_data`=4'hF, `cmd_ready`=1, `busy`=0, `done`=0, state IDLE, LFSR=8'hA5.
- Accept edge is T:
  - Bounce window: cycles T+1 .. T+B.
  - HOLD: cycles T+B+1 .. T+B+H.
  - Release bounce: the next B cycles.
  - `done` is high in the cycle after the last release-bounce cycle.
  - `cmd_ready` returns high in that same cycle.
  - Here B = `BOUNCE_CYCLES` and H = max(`cmd_hold`,1).
- `row_data` is registered: it reflects `col_data` and `contact` of the previous cycle, i.e. one cycle of latency. The scanner's 3-cycle settle covers this.
- Back-to-back commands: a new command may be accepted in the `done` cycle. Minimum spacing is 2B+H+1 cycles.
- Counters: the hold counter is 24 bits and the bounce counter is 8 bits. Neither wraps within legal values.

## Configuration
- `KEY_EMU_BOUNCE_EN` defined:
  - The bounce states and LFSR are compiled in, as described above.
- `KEY_EMU_BOUNCE_EN` not defined:
  - PRESS_BOUNCE, RELEASE_BOUNCE and the LFSR are absent.
  - IDLE goes to HOLD on accept. HOLD runs H cycles, then returns to IDLE with `done`.
  - Effective B=0: HOLD spans T+1..T+H and `done` is at T+H+1.
  - `BOUNCE_CYCLES` is ignored.

## Test plan
- Reset: assert `rst` with `col_data`=4'h0. Required: `row_data`=4'hF, `cmd_ready`=1, `busy`=0.
- Key 5 (r1,c1), bounce compiled out, H=10, `col_data`=4'b1011. Required: `row_data`=4'b1011 from T+2 to T+11, and 4'hF at T+12. `done` at T+11.
- Key D (r3,c3) in HOLD, sweeping `col_data` through 0111, 1011, 1101, 1110. Required: `row_data` = F, F, F, 4'b1110, each lagging its `col_data` value by 1 cycle.
- Bounce enabled, B=16, key 1, `col_data`=4'h0. Required: during T+1..T+16, `row_data[3]` follows the seeded LFSR bit0 sequence; then it is steady 0 for H cycles; `done` arrives exactly at T+32+H+1.
- `cmd_valid` held high while busy. Required: exactly one accept per command; the second command is accepted in the `done` cycle.
- `rst` pulse at mid-HOLD. Required: `row_data`=4'hF, `cmd_ready`=1 asynchronously, and no `done` pulse.

Source files
------------

// File: rtl/matrix_key_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_key_emulator
//  Purpose  : Contact side of a 4x4 active-low keypad matrix. Optional contact
//             bounce and its LFSR are compiled in with KEY_EMU_BOUNCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_key_emulator #(
    parameter int BOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [23:0] cmd_hold,
    input  logic [3:0]  col_data,
    output logic [3:0]  row_data,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd2;
`ifdef KEY_EMU_BOUNCE_EN
    localparam logic [1:0] c_ST_PRESS   = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;
    localparam logic [7:0] c_LFSR_SEED  = 8'hA5;
    localparam logic [7:0] c_BOUNCE_LAST = 8'(BOUNCE_CYCLES - 1);
`endif

    logic [1:0]  r_state;
    logic [3:0]  r_key;
    logic [23:0] r_hold_cnt;
    logic        r_done;
    logic [3:0]  r_row;
    logic        w_contact;
    logic [1:0]  w_row_sel;
    logic [1:0]  w_col_sel;
    logic [3:0]  w_row_next;
    logic [23:0] w_hold_last;

`ifdef KEY_EMU_BOUNCE_EN
    logic [7:0]  r_bounce_cnt;
    logic [7:0]  r_lfsr;
    logic [7:0]  w_lfsr_next;

    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting toward the MSB
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
`endif

    assign w_hold_last = (cmd_hold == 24'd0) ? 24'd0 : cmd_hold - 24'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_key      <= 4'h0;
            r_hold_cnt <= 24'd0;
            r_done     <= 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
            r_bounce_cnt <= 8'd0;
            r_lfsr       <= c_LFSR_SEED;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_key      <= cmd_key;
                        r_hold_cnt <= w_hold_last;
`ifdef KEY_EMU_BOUNCE_EN
                        r_bounce_cnt <= c_BOUNCE_LAST;
                        r_state      <= c_ST_PRESS;
`else
                        r_state      <= c_ST_HOLD;
`endif
                    end
                end
`ifdef KEY_EMU_BOUNCE_EN
                c_ST_PRESS: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_bounce_cnt == 8'd0) begin
                        r_state <= c_ST_HOLD;
                    end else begin
                        r_bounce_cnt <= r_bounce_cnt - 8'd1;
                    end
                end
`endif
                c_ST_HOLD: begin
                    if (r_hold_cnt == 24'd0) begin
`ifdef KEY_EMU_BOUNCE_EN
                        r_bounce_cnt <= c_BOUNCE_LAST;
                        r_state      <= c_ST_RELEASE;
`else
                        r_state      <= c_ST_IDLE;
                        r_done       <= 1'b1;
`endif
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 24'd1;
                    end
                end
`ifdef KEY_EMU_BOUNCE_EN
                c_ST_RELEASE: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_bounce_cnt == 8'd0) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_bounce_cnt <= r_bounce_cnt - 8'd1;
                    end
                end
`endif
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_contact = 1'b0;
        case (r_state)
            c_ST_HOLD:    w_contact = 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
            c_ST_PRESS:   w_contact = r_lfsr[0];
            c_ST_RELEASE: w_contact = r_lfsr[0];
`endif
            default:      w_contact = 1'b0;
        endcase
    end

    always_comb begin
        w_row_sel = 2'd0;
        w_col_sel = 2'd0;
        case (r_key)
            4'h1: begin w_row_sel = 2'd0; w_col_sel = 2'd0; end
            4'h2: begin w_row_sel = 2'd0; w_col_sel = 2'd1; end
            4'h3: begin w_row_sel = 2'd0; w_col_sel = 2'd2; end
            4'hA: begin w_row_sel = 2'd0; w_col_sel = 2'd3; end
            4'h4: begin w_row_sel = 2'd1; w_col_sel = 2'd0; end
            4'h5: begin w_row_sel = 2'd1; w_col_sel = 2'd1; end
            4'h6: begin w_row_sel = 2'd1; w_col_sel = 2'd2; end
            4'hB: begin w_row_sel = 2'd1; w_col_sel = 2'd3; end
            4'h7: begin w_row_sel = 2'd2; w_col_sel = 2'd0; end
            4'h8: begin w_row_sel = 2'd2; w_col_sel = 2'd1; end
            4'h9: begin w_row_sel = 2'd2; w_col_sel = 2'd2; end
            4'hC: begin w_row_sel = 2'd2; w_col_sel = 2'd3; end
            4'hF: begin w_row_sel = 2'd3; w_col_sel = 2'd0; end
            4'h0: begin w_row_sel = 2'd3; w_col_sel = 2'd1; end
            4'hE: begin w_row_sel = 2'd3; w_col_sel = 2'd2; end
            default: begin w_row_sel = 2'd3; w_col_sel = 2'd3; end
        endcase
    end

    // Bit index 3-n equals ~n for a 2-bit index
    always_comb begin
        w_row_next = 4'hF;
        if (w_contact) begin
            w_row_next[~w_row_sel] = col_data[~w_col_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= 4'hF;
        end else begin
            r_row <= w_row_next;
        end
    end

    assign row_data  = r_row;
    assign done      = r_done;
    assign cmd_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_key_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_key_emulator
//  Purpose  : Scoreboard bench for matrix_key_emulator; follows KEY_EMU_BOUNCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_key_emulator;

    localparam int B = 16;
`ifdef KEY_EMU_BOUNCE_EN
    localparam int BE = B;
`else
    localparam int BE = 0;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [23:0] cmd_hold;
    logic [3:0]  col_data;
    logic [3:0]  row_data;
    logic        busy;
    logic        done;

    matrix_key_emulator #(.BOUNCE_CYCLES(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .cmd_hold  (cmd_hold),
        .col_data  (col_data),
        .row_data  (row_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Key code -> (row, col) from the keypad layout
    int key_row [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int key_col [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 0};

    logic [3:0] row_q [$];
    int         done_q [$];

    logic [7:0] m_lfsr   = 8'hA5;
    bit         m_active = 1'b0;
    int         m_t      = 0;
    int         m_h      = 1;
    logic [3:0] m_key    = 4'h0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'b1011_1000)};
    endfunction

    function automatic logic [3:0] exp_row(input bit ct, input logic [3:0] key, input logic [3:0] col);
        logic [3:0] res;
        res = 4'hF;
        if (ct) res[3 - key_row[key]] = col[3 - key_col[key]];
        return res;
    endfunction

    // Reference model: contact by phase relative to the accept cycle
    initial forever begin : model
        bit ct;
        bit idle;
        int ph;
        @(negedge clk);
        if (rst) begin
            row_q.delete();
            row_q.push_back(4'hF);
            done_q.delete();
            m_active = 1'b0;
            m_lfsr   = 8'hA5;
        end else begin
            ct   = 1'b0;
            idle = 1'b1;
            if (m_active) begin
                ph = cyc - m_t;
                if (ph >= 1 && ph <= BE) begin
                    ct = m_lfsr[0];
                    m_lfsr = lfsr_step(m_lfsr);
                end else if (ph > BE && ph <= BE + m_h) begin
                    ct = 1'b1;
                end else if (ph > BE + m_h && ph <= 2 * BE + m_h) begin
                    ct = m_lfsr[0];
                    m_lfsr = lfsr_step(m_lfsr);
                end
                if (ph <= 2 * BE + m_h) idle = 1'b0;
            end
            check("cmd_ready", int'(cmd_ready), int'(idle));
            check("busy", int'(busy), int'(!idle));
            row_q.push_back(exp_row(ct, m_key, col_data));
            if (idle && cmd_valid) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_key    = cmd_key;
                m_h      = (cmd_hold == 24'd0) ? 1 : int'(cmd_hold);
                done_q.push_back(m_t + 2 * BE + m_h + 1);
            end
        end
    end

    initial forever begin : monitor
        @(negedge clk);
        if (!rst) begin
            if (row_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL row_q_empty at cycle %0d: got empty, required entry", cyc);
            end else begin
                check("row_data", int'(row_data), int'(row_q.pop_front()));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected at cycle %0d: got 1, required 0", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_ready(input int max_cycles);
        int n;
        n = 0;
        while (!cmd_ready && n < max_cycles) begin
            tick(1);
            n++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout at cycle %0d: got 0, required 1", cyc);
        end
    endtask

    task automatic send(input logic [3:0] key, input logic [23:0] hold, input logic [3:0] col);
        wait_ready(500);
        cmd_key   = key;
        cmd_hold  = hold;
        col_data  = col;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = 4'h0;
        cmd_hold  = 24'd0;
        col_data  = 4'h0;
        tick(3);
        check("reset_row", int'(row_data), 4'hF);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        tick(2);

        // Key 5, column 1 strobed
        send(4'h5, 24'd10, 4'b1011);
        wait_ready(500);
        tick(3);

        // Key D, sweep single-column strobes through the hold window
        send(4'hD, 24'd8, 4'b0111);
        tick(BE + 1);
        col_data = 4'b1011;
        tick(1);
        col_data = 4'b1101;
        tick(1);
        col_data = 4'b1110;
        tick(2);
        wait_ready(500);
        tick(2);

        // Hold of zero behaves as one cycle
        send(4'hA, 24'd0, 4'b1110);
        wait_ready(500);
        tick(2);

        // Key 1, all columns low: exercises the bounce sequence when enabled
        send(4'h1, 24'd6, 4'h0);
        wait_ready(500);
        tick(2);

        // cmd_valid held through busy: second command taken in the done cycle
        cmd_key   = 4'h2;
        cmd_hold  = 24'd3;
        col_data  = 4'h0;
        cmd_valid = 1'b1;
        tick(1);
        cmd_key  = 4'h7;
        cmd_hold = 24'd2;
        wait_ready(500);
        tick(1);
        cmd_valid = 1'b0;
        wait_ready(500);
        tick(2);

        // Asynchronous reset in the middle of a hold
        send(4'h9, 24'd20, 4'h0);
        tick(BE + 5);
        rst = 1'b1;
        #1;
        check("midrst_row", int'(row_data), 4'hF);
        check("midrst_ready", int'(cmd_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        tick(2);
        rst = 1'b0;
        tick(2 * BE + 30);

        // Service resumes after reset
        send(4'h0, 24'd4, 4'b1101);
        wait_ready(500);
        tick(3);

        check("done_pending", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout at cycle %0d: got running, required finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
